// File: rtl/memoria_datos_bytes_pkg.sv
// rtl/memoria_datos_bytes_pkg.sv - access size and FSM encodings for the byte-addressable data memory
package memoria_datos_bytes_pkg;

  typedef enum logic [1:0] {
    TAM_BYTE = 2'b00,
    TAM_HALF = 2'b01,
    TAM_WORD = 2'b10,
    TAM_RSV  = 2'b11
  } tamano_t;

  typedef enum logic {
    INIT  = 1'b0,
    LISTO = 1'b1
  } estado_t;

  // Reserved size counts as a bad access together with misalignment.
  function automatic logic acceso_invalido(input logic [1:0] tamano, input logic [1:0] dir);
    case (tamano_t'(tamano))
      TAM_BYTE: acceso_invalido = 1'b0;
      TAM_HALF: acceso_invalido = dir[0];
      TAM_WORD: acceso_invalido = (dir != 2'b00);
      default:  acceso_invalido = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/memoria_datos_alinear.sv
// rtl/memoria_datos_alinear.sv - little-endian load lane select with sign/zero extension
module memoria_datos_alinear
  import memoria_datos_bytes_pkg::*;
#(
  parameter int NBITS = 32
) (
  input  logic [NBITS-1:0] palabra,
  input  logic [1:0]       dir,
  input  logic [1:0]       tamano,
  input  logic             signo,
  output logic [NBITS-1:0] resultado
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (dir)
      2'd0:    byte_sel = palabra[7:0];
      2'd1:    byte_sel = palabra[15:8];
      2'd2:    byte_sel = palabra[23:16];
      default: byte_sel = palabra[31:24];
    endcase
    half_sel = dir[1] ? palabra[31:16] : palabra[15:0];
  end

  always_comb begin
    resultado = '0;
    case (tamano_t'(tamano))
      TAM_BYTE: resultado = {{(NBITS-8){signo & byte_sel[7]}}, byte_sel};
      TAM_HALF: resultado = {{(NBITS-16){signo & half_sel[15]}}, half_sel};
      TAM_WORD: resultado = palabra;
      default:  resultado = '0;
    endcase
  end

endmodule

// File: rtl/memoria_datos_bytes.sv
// rtl/memoria_datos_bytes.sv - byte-addressable data memory with self-initialisation and debug port
module memoria_datos_bytes
  import memoria_datos_bytes_pkg::*;
#(
  parameter int NBITS  = 32,
  parameter int CELDAS = 64
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [NBITS-1:0] i_ALUDireccion,
  input  logic [NBITS-1:0] i_DatoRegistro,
  input  logic             i_MemWrite,
  input  logic             i_MemRead,
  input  logic [1:0]       i_Tamano,
  input  logic             i_Signo,
  input  logic [NBITS-1:0] i_DebugDireccion,
  output logic [NBITS-1:0] o_DatoLeido,
  output logic [NBITS-1:0] o_DebugDato,
  output logic             o_Listo,
  output logic             o_Error
);

  localparam int IW = $clog2(CELDAS);
  localparam int NB = NBITS / 8;

  logic [NBITS-1:0] mem [CELDAS];

  estado_t        estado, estado_sig;
  logic [IW-1:0]  k, k_sig;

  logic [NBITS-3:0] dir_palabra;
  logic [IW-1:0]    idx;
  logic [IW-1:0]    dbg_idx;
  logic             fuera_rango;
  logic             dbg_fuera;
  logic             error_acc;
  logic             listo;
  logic             store_ok;
  logic [NB-1:0]    be;
  logic [NBITS-1:0] wdata;
  logic [NBITS-1:0] dato_alineado;

  assign dir_palabra = i_ALUDireccion[NBITS-1:2];
  assign idx         = dir_palabra[IW-1:0];
  assign fuera_rango = dir_palabra >= (NBITS-2)'(CELDAS);
  assign dbg_idx     = i_DebugDireccion[IW-1:0];
  assign dbg_fuera   = i_DebugDireccion >= NBITS'(CELDAS);
  assign error_acc   = fuera_rango | acceso_invalido(i_Tamano, i_ALUDireccion[1:0]);
  assign listo       = (estado == LISTO);
  assign store_ok    = listo & i_MemWrite & ~error_acc;
  assign o_Listo     = listo;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      estado <= INIT;
      k      <= '0;
    end else begin
      estado <= estado_sig;
      k      <= k_sig;
    end
  end

  always_comb begin
    estado_sig = estado;
    k_sig      = k;
    case (estado)
      INIT: begin
        k_sig = k + 1'b1;
        if (k == IW'(CELDAS - 1)) estado_sig = LISTO;
      end
      default: ;
    endcase
  end

  // Store data is replicated across lanes; the byte enables pick the target lanes.
  always_comb begin
    be    = '0;
    wdata = '0;
    case (tamano_t'(i_Tamano))
      TAM_BYTE: begin
        be    = NB'(1) << i_ALUDireccion[1:0];
        wdata = {NB{i_DatoRegistro[7:0]}};
      end
      TAM_HALF: begin
        be    = NB'(2'b11) << {i_ALUDireccion[1], 1'b0};
        wdata = {(NB/2){i_DatoRegistro[15:0]}};
      end
      TAM_WORD: begin
        be    = '1;
        wdata = i_DatoRegistro;
      end
      default: ;
    endcase
  end

  // Array has no reset: INIT rewrites every word after each reset.
  always_ff @(posedge i_clk) begin
    if (estado == INIT) begin
      mem[k] <= NBITS'(k);
    end else if (store_ok) begin
      for (int b = 0; b < NB; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  memoria_datos_alinear #(
    .NBITS(NBITS)
  ) u_alinear (
    .palabra  (mem[idx]),
    .dir      (i_ALUDireccion[1:0]),
    .tamano   (i_Tamano),
    .signo    (i_Signo),
    .resultado(dato_alineado)
  );

  // Reads sample the array before this edge's store lands, giving read-first behaviour.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      o_DatoLeido <= '0;
      o_DebugDato <= '0;
      o_Error     <= 1'b0;
    end else begin
      if (listo && i_MemRead) o_DatoLeido <= error_acc ? '0 : dato_alineado;
      o_Error     <= listo & (i_MemRead | i_MemWrite) & error_acc;
      o_DebugDato <= dbg_fuera ? '0 : mem[dbg_idx];
    end
  end

endmodule

// File: tb/tb_memoria_datos_bytes.sv
// tb/tb_memoria_datos_bytes.sv - self-checking bench for memoria_datos_bytes
module tb_memoria_datos_bytes;

  localparam int NBITS  = 32;
  localparam int CELDAS = 64;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NBITS-1:0] dir, dato_reg, dbg_dir;
  logic             mem_write, mem_read, signo;
  logic [1:0]       tamano;
  logic [NBITS-1:0] dato_leido, debug_dato;
  logic             listo, error_o;

  memoria_datos_bytes #(.NBITS(NBITS), .CELDAS(CELDAS)) dut (
    .i_clk           (clk),
    .i_reset         (rst_n),
    .i_ALUDireccion  (dir),
    .i_DatoRegistro  (dato_reg),
    .i_MemWrite      (mem_write),
    .i_MemRead       (mem_read),
    .i_Tamano        (tamano),
    .i_Signo         (signo),
    .i_DebugDireccion(dbg_dir),
    .o_DatoLeido     (dato_leido),
    .o_DebugDato     (debug_dato),
    .o_Listo         (listo),
    .o_Error         (error_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] mem_m [CELDAS];
  logic [31:0] m_dato, m_dbg;
  logic        m_err;

  typedef struct {
    bit          rd;
    bit          wr;
    logic [1:0]  sz;
    bit          sg;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp_dato;
    bit          exp_err;
    string       name;
  } vec_t;

  vec_t tabla[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic bit model_err(input logic [1:0] sz, input logic [31:0] a);
    return (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0)
           || ((a >> 2) >= CELDAS);
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] w, input logic [1:0] sz,
                                             input bit sg, input int off);
    logic [31:0] v;
    case (sz)
      2'd0: begin
        v = (w >> (8 * off)) & 32'hFF;
        if (sg && v >= 32'h80) v = v | 32'hFFFFFF00;
      end
      2'd1: begin
        v = (w >> (8 * off)) & 32'hFFFF;
        if (sg && v >= 32'h8000) v = v | 32'hFFFF0000;
      end
      2'd2: v = w;
      default: v = 32'h0;
    endcase
    return v;
  endfunction

  task automatic model_init();
    for (int i = 0; i < CELDAS; i++) mem_m[i] = i;
    m_dato = 32'h0;
  endtask

  task automatic do_op(input bit rd, input bit wr, input logic [1:0] sz, input bit sg,
                       input logic [31:0] a, input logic [31:0] d, input logic [31:0] dbg);
    bit          e;
    int          off;
    logic [31:0] mask, ext;
    e     = model_err(sz, a);
    off   = int'(a[1:0]);
    m_dbg = (dbg < CELDAS) ? mem_m[dbg] : 32'h0;
    if (rd) m_dato = e ? 32'h0 : model_load(mem_m[a >> 2], sz, sg, off);
    m_err = (rd || wr) && e;
    mem_read = rd; mem_write = wr; tamano = sz; signo = sg;
    dir = a; dato_reg = d; dbg_dir = dbg;
    @(posedge clk); #1;
    mem_read = 1'b0; mem_write = 1'b0;
    if (wr && !e) begin
      mask = (sz == 2'd0) ? 32'hFF : (sz == 2'd1) ? 32'hFFFF : 32'hFFFFFFFF;
      ext  = (d & mask) << (8 * off);
      mask = mask << (8 * off);
      mem_m[a >> 2] = (mem_m[a >> 2] & ~mask) | ext;
    end
  endtask

  // Counts edges until o_Listo; also issues requests that INIT must ignore.
  task automatic wait_ready(input string name);
    int cnt = 0;
    bit bad = 0;
    dir = 32'h14; dato_reg = 32'hFFFFFFFF; signo = 1'b0;
    mem_read = 1'b1; mem_write = 1'b1;
    while (!listo && cnt < 4 * CELDAS) begin
      tamano = cnt[0] ? 2'd3 : 2'd2;
      @(posedge clk); #1;
      cnt++;
      if (!listo && (error_o !== 1'b0 || dato_leido !== 32'h0)) bad = 1;
    end
    mem_read = 1'b0; mem_write = 1'b0;
    chk({name, "_listo_cycles"}, cnt, CELDAS);
    chk({name, "_init_ignored"}, 32'(bad), 32'h0);
    model_init();
  endtask

  initial begin
    logic [31:0] held;
    rst_n = 1'b0; dir = '0; dato_reg = '0; dbg_dir = '0;
    mem_write = 1'b0; mem_read = 1'b0; tamano = 2'd2; signo = 1'b0;
    #12;
    chk("rst_listo", 32'(listo), 32'h0);
    chk("rst_error", 32'(error_o), 32'h0);
    chk("rst_dato", dato_leido, 32'h0);
    chk("rst_debug", debug_dato, 32'h0);
    #10 rst_n = 1'b1;
    wait_ready("init1");

    do_op(0, 0, 2'd2, 0, 32'h0, 32'h0, 32'd5);
    chk("dbg_5", debug_dato, 32'h5);

    tabla.push_back('{0, 1, 2'd2, 0, 32'h10, 32'hA1B2C3D4, 32'h0, 0, "sw_10"});
    tabla.push_back('{1, 0, 2'd0, 1, 32'h13, 32'h0, 32'hFFFFFFA1, 0, "lb_13"});
    tabla.push_back('{1, 0, 2'd0, 0, 32'h12, 32'h0, 32'h000000B2, 0, "lbu_12"});
    tabla.push_back('{1, 0, 2'd1, 1, 32'h12, 32'h0, 32'hFFFFA1B2, 0, "lh_12"});
    tabla.push_back('{1, 0, 2'd2, 0, 32'h10, 32'h0, 32'hA1B2C3D4, 0, "lw_10"});
    tabla.push_back('{1, 0, 2'd0, 1, 32'h10, 32'h0, 32'hFFFFFFD4, 0, "lb_10"});
    tabla.push_back('{0, 1, 2'd0, 0, 32'h11, 32'hFFFFFF55, 32'h0, 0, "sb_11"});
    tabla.push_back('{1, 0, 2'd2, 1, 32'h10, 32'h0, 32'hA1B255D4, 0, "lw_after_sb"});
    tabla.push_back('{0, 1, 2'd1, 0, 32'h12, 32'hABCD1234, 32'h0, 0, "sh_12"});
    tabla.push_back('{1, 0, 2'd2, 0, 32'h10, 32'h0, 32'h123455D4, 0, "lw_after_sh"});
    tabla.push_back('{1, 0, 2'd1, 0, 32'h10, 32'h0, 32'h000055D4, 0, "lhu_10"});
    tabla.push_back('{0, 0, 2'd2, 0, 32'h10, 32'h0, 32'h0, 0, "idle"});
    tabla.push_back('{1, 0, 2'd2, 0, 32'h11, 32'h0, 32'h0, 1, "lw_misaligned"});
    tabla.push_back('{0, 0, 2'd2, 0, 32'h0, 32'h0, 32'h0, 0, "idle_after_err"});
    tabla.push_back('{0, 1, 2'd1, 0, 32'h21, 32'hFFFF, 32'h0, 1, "sh_misaligned"});
    tabla.push_back('{1, 0, 2'd2, 0, 32'h20, 32'h0, 32'h8, 0, "lw_20_unchanged"});
    tabla.push_back('{1, 0, 2'd3, 0, 32'h10, 32'h0, 32'h0, 1, "load_rsv"});
    tabla.push_back('{0, 1, 2'd3, 0, 32'h10, 32'h0, 32'h0, 1, "store_rsv"});
    tabla.push_back('{1, 0, 2'd2, 0, 32'h10, 32'h0, 32'h123455D4, 0, "lw_10_unchanged"});
    tabla.push_back('{1, 0, 2'd2, 0, 4 * CELDAS, 32'h0, 32'h0, 1, "lw_out_of_range"});
    tabla.push_back('{0, 1, 2'd2, 0, 4 * CELDAS + 4, 32'h77777777, 32'h0, 1, "sw_out_of_range"});
    tabla.push_back('{1, 0, 2'd2, 0, 32'h04, 32'h0, 32'h1, 0, "lw_04_unchanged"});
    tabla.push_back('{1, 1, 2'd2, 0, 32'h08, 32'hDEADBEEF, 32'h2, 0, "rw_08_read_first"});
    tabla.push_back('{1, 0, 2'd2, 0, 32'h08, 32'h0, 32'hDEADBEEF, 0, "lw_08_after"});

    held = 32'h0;
    foreach (tabla[i]) begin
      do_op(tabla[i].rd, tabla[i].wr, tabla[i].sz, tabla[i].sg, tabla[i].addr, tabla[i].data, 32'd0);
      if (tabla[i].rd) held = tabla[i].exp_dato;
      chk({tabla[i].name, "_dato"}, dato_leido, held);
      chk({tabla[i].name, "_error"}, 32'(error_o), 32'(tabla[i].exp_err));
    end

    do_op(0, 0, 2'd2, 0, 32'h0, 32'h0, 32'd4);
    chk("dbg_4", debug_dato, 32'h123455D4);
    do_op(0, 0, 2'd2, 0, 32'h0, 32'h0, CELDAS);
    chk("dbg_out_of_range", debug_dato, 32'h0);

    for (int i = 0; i < 400; i++) begin
      logic [31:0] a;
      a = 4 * $urandom_range(0, CELDAS + 3) + $urandom_range(0, 3);
      if ($urandom_range(0, 15) == 0) a = $urandom;
      do_op(1'($urandom), 1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom),
            a, $urandom, $urandom_range(0, CELDAS + 3));
      chk($sformatf("rand%0d_dato", i), dato_leido, m_dato);
      chk($sformatf("rand%0d_error", i), 32'(error_o), 32'(m_err));
      chk($sformatf("rand%0d_debug", i), debug_dato, m_dbg);
    end

    do_op(0, 1, 2'd2, 0, 32'h0, 32'hCAFEF00D, 32'd0);
    do_op(1, 0, 2'd2, 0, 32'h0, 32'h0, 32'd0);
    chk("pre_reset_dato", dato_leido, 32'hCAFEF00D);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_dato", dato_leido, 32'h0);
    chk("async_rst_listo", 32'(listo), 32'h0);
    #2 rst_n = 1'b1;
    wait_ready("init2");

    dbg_dir = 32'd5;
    #2 rst_n = 1'b0;
    #3 rst_n = 1'b1;
    for (int i = 0; i < CELDAS / 2; i++) begin
      @(posedge clk); #1;
    end
    chk("mid_init_debug", debug_dato, 32'h5);
    chk("mid_init_listo", 32'(listo), 32'h0);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_init_rst_debug", debug_dato, 32'h0);
    chk("mid_init_rst_listo", 32'(listo), 32'h0);
    #2 rst_n = 1'b1;
    wait_ready("init3");
    do_op(1, 0, 2'd2, 0, 32'h08, 32'h0, 32'd0);
    chk("lw_08_after_reinit", dato_leido, 32'h2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/memoria_datos_bytes.md
MEMORIA_DATOS_BYTES -- requirements
Module: memoria_datos_bytes

Interface
REQ-001 SHALL have parameter NBITS, default 32, data word width; legal values are 32 only.
REQ-002 SHALL have parameter CELDAS, default 64, number of words; a power of two, 4..1024.
REQ-003 SHALL have port i_clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port i_reset  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port i_ALUDireccion  input  NBITS  byte address; word index = addr[NBITS-1:2].
REQ-006 SHALL have port i_DatoRegistro  input  NBITS  store data, right-justified for byte/half.
REQ-007 SHALL have port i_MemWrite  input  1  store request this cycle.
REQ-008 SHALL have port i_MemRead  input  1  load request this cycle.
REQ-009 SHALL have port i_Tamano  input  2  access size: 00 byte, 01 half, 10 word, 11 reserved.
REQ-010 SHALL have port i_Signo  input  1  1 = sign-extend byte/half loads, 0 = zero-extend.
REQ-011 SHALL have port i_DebugDireccion  input  NBITS  debug word index (not byte address).
REQ-012 SHALL have port o_DatoLeido  output  NBITS  load result.
REQ-013 SHALL have port o_DebugDato  output  NBITS  debug word.
REQ-014 SHALL have port o_Listo  output  1  1 = initialisation done, accesses accepted.
REQ-015 SHALL have port o_Error  output  1  one-cycle flag: misaligned, reserved size or out-of-range access.

Function
REQ-016 SHALL implement FSM states INIT and LISTO; reset enters INIT with counter k = 0.
REQ-017 In INIT SHALL write memory[k] = k each cycle, increment k, go to LISTO after k = CELDAS-1; o_Listo = 0 throughout INIT.
REQ-018 In INIT SHALL ignore i_MemRead/i_MemWrite: no memory change, o_DatoLeido held, o_Error = 0.
REQ-019 Load latency SHALL be 1 cycle: request in cycle n -> o_DatoLeido valid from edge n+1, held until the next accepted load.
REQ-020 Byte lanes SHALL be little-endian: addr[1:0]=0 selects bits 7:0; half at addr[1]=0 selects bits 15:0.
REQ-021 Byte/half loads SHALL extend to NBITS per i_Signo; word loads ignore i_Signo.
REQ-022 Stores SHALL write only the addressed byte lanes (byte-enable); other lanes unchanged.
REQ-023 Error cases: half with addr[0]=1; word with addr[1:0]!=0; i_Tamano=11; word index >= CELDAS.
REQ-024 On an error case SHALL suppress the store, load returns 0, and o_Error = 1 for exactly the cycle after the request.
REQ-025 Load and store in the same cycle to the same word SHALL return the pre-store data (read-first); the store still takes effect.
REQ-026 o_DebugDato SHALL be registered, 1-cycle latency, continuously updated each cycle (including INIT); index >= CELDAS returns 0.
REQ-027 o_Error SHALL be 0 in any cycle following no request.

Reset
REQ-028 On i_reset low SHALL asynchronously set o_DatoLeido=0, o_DebugDato=0, o_Error=0, o_Listo=0, FSM=INIT, k=0.
REQ-029 Reset asserted mid-INIT or mid-operation SHALL restart INIT from k=0 after release; memory contents are rewritten, not cleared asynchronously.

Structure
REQ-030 Shared package/include SHALL hold i_Tamano encodings (BYTE, HALF, WORD) and FSM state encodings (INIT, LISTO).
REQ-031 Load lane-select and extension logic SHALL be one combinational sub-module, memoria_datos_alinear (inputs: word, addr[1:0], size, sign; output: NBITS result).
REQ-032 Memory array SHALL be a single NBITS x CELDAS register array with per-byte write enables.

Verification
REQ-033 Reset, then count cycles -> o_Listo rises exactly CELDAS cycles after release; debug read of index 5 -> 0x00000005.
REQ-034 SW 0xA1B2C3D4 at 0x10, then LB sign at 0x13, LBU at 0x12, LH sign at 0x12, LW at 0x10 -> 0xFFFFFFA1, 0x000000B2, 0xFFFFA1B2, 0xA1B2C3D4.
REQ-035 SB 0x55 at 0x11 over 0xA1B2C3D4 -> LW 0x10 = 0xA1B255D4; SH 0x1234 at 0x12 -> LW 0x10 = 0x123455D4.
REQ-036 LW at 0x11, SH at 0x21, size 11 and LW at byte address 4*CELDAS -> o_Error pulses 1 cycle each, load returns 0, memory unchanged.
REQ-037 Same-cycle LW+SW 0xDEADBEEF at 0x08 (old 0x00000002) -> o_DatoLeido = 0x00000002; next LW 0x08 = 0xDEADBEEF.
REQ-038 Assert i_reset low with k = CELDAS/2 during INIT -> outputs 0 immediately; after release o_Listo rises after a full CELDAS cycles; word at 0x08 reads 0x00000002.
